hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit core.
- Produces PC/IF-ID/ID-EX/EX-MEM write, bubble and flush controls.
- Detects the hazards that the forwarding network cannot cover: load-use, branch operand not yet forwardable, and taken-branch flush.
- Holds EX with a cycle counter while a multi-cycle multiply or divide occupies the ALU. Also keeps a saturating stall-cycle statistic.

Parameters:
- MUL_CYCLES, 4, total EX-stage occupancy of a multiply in cycles (legal range 2..15).
- DIV_CYCLES, 8, total EX-stage occupancy of a divide in cycles (legal range 2..15).

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_op1  in  4  Op1 register address of the instruction in ID
- id_op2  in  4  Op2 register address of the instruction in ID
- id_uses_op2  in  1  ID instruction reads Op2
- id_is_branch  in  1  ID instruction is a conditional branch (compares id_op1)
- branch_taken  in  1  branch comparison result in ID
- ex_op1  in  4  destination address of the EX instruction
- ex_regwrite  in  2  EX write-enable code; 2'b00 = no register write
- ex_memread  in  1  EX instruction is a load
- ex_is_muldiv  in  1  EX instruction is a multiply or divide
- ex_is_div  in  1  qualifies ex_is_muldiv: 1 = divide, 0 = multiply
- mem_op1  in  4  destination address of the MEM instruction
- mem_memread  in  1  MEM instruction is a load
- stat_clear  in  1  clears stall_count
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear (NOP insert)
- idex_write  out  1  ID/EX register enable
- idex_bubble  out  1  ID/EX loads NOP
- exmem_bubble  out  1  EX/MEM loads NOP
- muldiv_start  out  1  ALU latches operands and starts its iteration
- muldiv_done  out  1  final EX cycle of a multiply/divide
- busy  out  1  FSM is in S_MULDIV
- stall_count  out  16  saturating count of cycles with pc_write = 0

Behaviour:
- FSM states: S_RUN and S_MULDIV, encoded 2 bits. cnt is 4 bits.
- Reset:
  - While rst_n = 0, outputs are combinationally forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_bubble=1, muldiv_start=0, muldiv_done=0, busy=0.
  - On the reset clock edge: state <= S_RUN, cnt <= 0, stall_count <= 0.
  - Reset during S_MULDIV abandons the operation; no muldiv_done is issued.
- Default outputs (S_RUN, no event): pc_write=1, ifid_write=1, idex_write=1, all bubble/flush/pulse outputs 0.
- S_RUN evaluation, in priority order (first match wins):
  1. Multiply/divide start. Condition: ex_is_muldiv. Outputs: muldiv_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1. Next state: cnt <= (ex_is_div ? DIV_CYCLES : MUL_CYCLES) - 2, state <= S_MULDIV.
  2. Load-use hazard. Condition: ex_memread & (ex_op1==id_op1 | (id_uses_op2 & ex_op1==id_op2)). Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  3. Branch operand hazard. Condition: id_is_branch & ((ex_regwrite!=2'b00 & ex_op1==id_op1) | (mem_memread & mem_op1==id_op1)). Outputs: same as item 2. A load feeding a branch therefore stalls 2 cycles.
  4. Taken branch. Condition: id_is_branch & branch_taken. Output: ifid_flush=1, all else default.
- Timing consequences:
  - branch_taken is ignored on any cycle where items 1-3 match.
  - Flush occurs exactly once, on the cycle the branch leaves ID.
- S_MULDIV:
  - busy=1. ID and EX hazards are not evaluated; branch_taken is ignored.
  - While cnt != 0: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1; cnt decrements.
  - When cnt == 0: muldiv_done=1, default enables (pipeline advances), state <= S_RUN.
  - EX occupancy is exactly MUL_CYCLES or DIV_CYCLES cycles. Back-to-back multiply/divide operations restart on the following cycle.
- stall_count:
  - stat_clear has priority and loads 0.
  - Otherwise it increments on every cycle with rst_n=1 and pc_write=0.
  - It saturates at 16'hFFFF and does not wrap.
- Register address comparisons are full 4-bit equality. R0 is not special-cased.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding S_RUN=2'b00, S_MULDIV=2'b01;
  - REGWRITE_NONE=2'b00;
  - the default MUL_CYCLES and DIV_CYCLES values.
- One sub-module, sat_counter16: stall_count with clear, increment enable and saturation.
- Hazard decode and FSM remain in hazard_control_unit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ex_is_muldiv=1 -> outputs at reset values, no muldiv_start. Release -> pc_write=1, busy=0, stall_count=0.
- Load-use: ex_memread=1, ex_op1=4'h3, id_op2=4'h3, id_uses_op2=1 -> exactly 1 cycle with pc_write=0 and idex_bubble=1. Same case with id_uses_op2=0 -> no stall.
- Load into branch: load R5 in EX, branch on R5 in ID, branch_taken=1 -> 2 stall cycles, then ifid_flush=1 for 1 cycle. stall_count increases by 2.
- Multiply (MUL_CYCLES=4) in EX -> muldiv_start on cycle 0, busy on cycles 1-3, muldiv_done on cycle 3, pc_write=0 on cycles 0-2. Divide back-to-back -> second muldiv_start on cycle 4, done on cycle 11.
- Reset mid-divide: assert rst_n=0 at cycle 3 of a divide -> state S_RUN, muldiv_done never asserted, busy=0 after the reset edge.
- Counter: force ~70000 stall cycles -> stall_count holds 16'hFFFF. stat_clear on a stalled cycle -> reads 0 next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: FSM state encoding, register-write code constants, default
//          multiply/divide EX occupancy, and the cycle-counter load helper.
// Ports:   none (package)
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_MULDIV = 2'b01
  } hcu_state_t;

  localparam logic [1:0] REGWRITE_NONE = 2'b00;

  localparam int MUL_CYCLES_DEFAULT = 4;
  localparam int DIV_CYCLES_DEFAULT = 8;

  // The start cycle and the done cycle are both part of the occupancy,
  // so the countdown covers the remaining cycles minus those two.
  function automatic logic [3:0] muldiv_load(input int cycles);
    return 4'(cycles - 2);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating event counter with clear
// Purpose: counts enabled cycles, sticks at 16'hFFFF, clear wins over increment.
// Ports:   clk, rst_n (sync, active-low), clear, inc -> count[15:0]
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (clear) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - 5-stage pipeline stall/bubble/flush sequencer
// Purpose: detects load-use, branch-operand and taken-branch hazards, holds EX
//          for multi-cycle multiply/divide, and keeps a stall-cycle statistic.
// Ports:   clk, rst_n (sync, active-low)
//          ID  : id_op1, id_op2, id_uses_op2, id_is_branch, branch_taken
//          EX  : ex_op1, ex_regwrite, ex_memread, ex_is_muldiv, ex_is_div
//          MEM : mem_op1, mem_memread
//          stat_clear
//          out : pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
//                exmem_bubble, muldiv_start, muldiv_done, busy, stall_count
module hazard_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_op1,
  input  logic [3:0]  id_op2,
  input  logic        id_uses_op2,
  input  logic        id_is_branch,
  input  logic        branch_taken,
  input  logic [3:0]  ex_op1,
  input  logic [1:0]  ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_is_muldiv,
  input  logic        ex_is_div,
  input  logic [3:0]  mem_op1,
  input  logic        mem_memread,
  input  logic        stat_clear,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        muldiv_start,
  output logic        muldiv_done,
  output logic        busy,
  output logic [15:0] stall_count
);

  localparam logic [3:0] MUL_LOAD = muldiv_load(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = muldiv_load(DIV_CYCLES);

  hcu_state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       load_use, branch_hazard;

  assign load_use = ex_memread &&
                    ((ex_op1 == id_op1) || (id_uses_op2 && (ex_op1 == id_op2)));

  // The branch compares in ID, so its operand must already be in the register
  // file or forwardable: any EX producer, or a load still in MEM, is too late.
  assign branch_hazard = id_is_branch &&
                         (((ex_regwrite != REGWRITE_NONE) && (ex_op1 == id_op1)) ||
                          (mem_memread && (mem_op1 == id_op1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_start = 1'b0;
    muldiv_done  = 1'b0;
    busy         = 1'b0;
    state_next   = state;
    cnt_next     = cnt;

    if (!rst_n) begin
      // Pipeline is drained with NOPs while reset is held.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (ex_is_muldiv) begin
            muldiv_start = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cnt_next     = ex_is_div ? DIV_LOAD : MUL_LOAD;
            state_next   = S_MULDIV;
          end else if (load_use || branch_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_is_branch && branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        S_MULDIV: begin
          busy = 1'b1;
          if (cnt != 4'd0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cnt_next     = cnt - 4'd1;
          end else begin
            muldiv_done = 1'b1;
            state_next  = S_RUN;
          end
        end
        default: state_next = S_RUN;
      endcase
    end
  end

  sat_counter16 u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (stat_clear),
    .inc   (!pc_write),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_op1, id_op2, ex_op1, mem_op1;
  logic        id_uses_op2, id_is_branch, branch_taken;
  logic [1:0]  ex_regwrite;
  logic        ex_memread, ex_is_muldiv, ex_is_div, mem_memread, stat_clear;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic        exmem_bubble, muldiv_start, muldiv_done, busy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: EX cycles still owed to a multiply/divide after the
  // current one, and the stall statistic as a plain integer.
  int m_left   = 0;
  int m_stall  = 0;
  bit stat_ok  = 0;
  int done_seen;

  always #5 clk = ~clk;

  hazard_control_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_op1(id_op1), .id_op2(id_op2), .id_uses_op2(id_uses_op2),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_is_muldiv(ex_is_muldiv), .ex_is_div(ex_is_div),
    .mem_op1(mem_op1), .mem_memread(mem_memread), .stat_clear(stat_clear),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .muldiv_start(muldiv_start),
    .muldiv_done(muldiv_done), .busy(busy), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected controls {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
  //                    exmem_bubble, muldiv_start, muldiv_done, busy}
  function automatic logic [8:0] ref_ctl();
    bit lu, bh;
    if (!rst_n) return 9'b0_0_1_1_1_1_0_0_0;
    if (m_left > 0) return (m_left > 1) ? 9'b0_0_0_0_0_1_0_0_1 : 9'b1_1_0_1_0_0_0_1_1;
    if (ex_is_muldiv) return 9'b0_0_0_0_0_1_1_0_0;
    lu = ex_memread && (ex_op1 == id_op1 || (id_uses_op2 && ex_op1 == id_op2));
    bh = id_is_branch && ((ex_regwrite != 2'b00 && ex_op1 == id_op1) ||
                          (mem_memread && mem_op1 == id_op1));
    if (lu || bh) return 9'b0_0_0_1_1_0_0_0_0;
    if (id_is_branch && branch_taken) return 9'b1_1_1_1_0_0_0_0_0;
    return 9'b1_1_0_1_0_0_0_0_0;
  endfunction

  // Called 1 time unit after the falling edge: compare, clock, advance model.
  task automatic cycle();
    logic [8:0] e;
    e = ref_ctl();
    check("ctl", 32'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                      exmem_bubble, muldiv_start, muldiv_done, busy}), 32'(e));
    if (stat_ok) check("stall_count", 32'(stall_count), 32'(m_stall));
    if (muldiv_done) done_seen++;
    @(posedge clk);
    if (!rst_n) begin
      m_left  = 0;
      m_stall = 0;
      stat_ok = 1;
    end else begin
      if (stat_clear) m_stall = 0;
      else if (!e[8] && m_stall < 65535) m_stall = m_stall + 1;
      if (m_left > 0) m_left = m_left - 1;
      else if (ex_is_muldiv) m_left = (ex_is_div ? DIV_N : MUL_N) - 1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    cycle();
  endtask

  task automatic idle();
    rst_n = 1; id_op1 = 4'h1; id_op2 = 4'h2; id_uses_op2 = 0; id_is_branch = 0;
    branch_taken = 0; ex_op1 = 4'h9; ex_regwrite = 2'b00; ex_memread = 0;
    ex_is_muldiv = 0; ex_is_div = 0; mem_op1 = 4'hA; mem_memread = 0; stat_clear = 0;
  endtask

  task automatic rand_inputs();
    rst_n        = ($urandom_range(0, 63) != 0);
    id_op1       = 4'($urandom_range(0, 3));
    id_op2       = 4'($urandom_range(0, 3));
    ex_op1       = 4'($urandom_range(0, 3));
    mem_op1      = 4'($urandom_range(0, 3));
    id_uses_op2  = 1'($urandom);
    id_is_branch = 1'($urandom);
    branch_taken = 1'($urandom);
    ex_regwrite  = 2'($urandom);
    ex_memread   = ($urandom_range(0, 2) == 0);
    mem_memread  = ($urandom_range(0, 2) == 0);
    ex_is_muldiv = ($urandom_range(0, 9) == 0);
    ex_is_div    = 1'($urandom);
    stat_clear   = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    int base;
    idle();
    // Reset held 2 cycles with a multiply presented: no start allowed.
    rst_n = 0; ex_is_muldiv = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_start", 32'(muldiv_start), 32'd0);
      cycle();
    end
    idle();
    #1;
    check("rel_pc_write", 32'(pc_write), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_stall_count", 32'(stall_count), 32'd0);
    cycle();

    // Load-use on Op2: one stall, then free.
    ex_memread = 1; ex_op1 = 4'h3; id_op2 = 4'h3; id_uses_op2 = 1;
    #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    cycle();
    idle();
    tick();
    ex_memread = 1; ex_op1 = 4'h3; id_op2 = 4'h3; id_uses_op2 = 0;
    #1;
    check("lu_no_op2", 32'(pc_write), 32'd1);
    cycle();

    // Load R5 feeding a taken branch: 2 stalls, then a single flush.
    idle();
    base = m_stall;
    ex_memread = 1; ex_regwrite = 2'b01; ex_op1 = 4'h5;
    id_is_branch = 1; id_op1 = 4'h5; branch_taken = 1;
    #1; check("lb_stall1", 32'(pc_write), 32'd0); check("lb_flush1", 32'(ifid_flush), 32'd0);
    cycle();
    ex_memread = 0; ex_regwrite = 2'b00; ex_op1 = 4'h0; mem_memread = 1; mem_op1 = 4'h5;
    #1; check("lb_stall2", 32'(pc_write), 32'd0); check("lb_flush2", 32'(ifid_flush), 32'd0);
    cycle();
    mem_memread = 0;
    #1; check("lb_flush", 32'(ifid_flush), 32'd1);
    cycle();
    idle();
    #1; check("lb_stall_delta", 32'(stall_count - 16'(base)), 32'd2);
    cycle();

    // Multiply then divide back-to-back, ex_is_muldiv held throughout.
    done_seen = 0;
    ex_is_muldiv = 1;
    for (int c = 0; c < 12; c++) begin
      ex_is_div = (c >= 4);
      #1;
      check($sformatf("md_start_c%0d", c), 32'(muldiv_start), 32'((c == 0 || c == 4) ? 1 : 0));
      check($sformatf("md_done_c%0d", c), 32'(muldiv_done), 32'((c == 3 || c == 11) ? 1 : 0));
      check($sformatf("md_pc_c%0d", c), 32'(pc_write), 32'((c == 3 || c == 11) ? 1 : 0));
      cycle();
    end
    idle();
    tick();

    // Reset on cycle 3 of a divide abandons it.
    done_seen = 0;
    ex_is_muldiv = 1; ex_is_div = 1;
    for (int c = 0; c < 3; c++) tick();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    check("rd_busy", 32'(busy), 32'd0);
    cycle();
    for (int c = 0; c < 8; c++) tick();
    check("rd_no_done", 32'(done_seen), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end

    // Saturation: continuous load-use stall for 70000 cycles.
    idle();
    tick();
    ex_memread = 1; ex_op1 = id_op1;
    for (int c = 0; c < 70000; c++) tick();
    #1;
    check("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    stat_clear = 1;
    cycle();
    stat_clear = 0;
    #1;
    check("sat_cleared", 32'(stall_count), 32'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
